spi_cmd_slave_rx: RTL and testbench

- On-chip SPI slave front end; directly consumes the 32-bit command frames produced by the SPI master (sck, mosi, cs_n) and returns read data on miso.
- Oversamples the SPI pins in the clk_50M domain and deserializes each LSB-first frame.
- Presents each frame as a parallel {code, addr, data} command with a one-cycle valid strobe to the downstream command decoder.
- Serializes a preloaded 32-bit response word on miso during the next frame.

---
 rtl/spi_cmd_slave_rx_pkg.sv | 43 ++++
 rtl/spi_cmd_slave_rx_sync_edge.sv | 34 +++
 rtl/spi_cmd_slave_rx.sv | 139 +++++++++++++
 tb/tb_spi_cmd_slave_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_slave_rx_pkg.sv
// Shared widths, field offsets, command codes and FSM encoding for the SPI command slave.
package spi_cmd_slave_rx_pkg;

  localparam int LEN_SPI      = 32;
  localparam int SPI_CODE_LEN = 6;
  localparam int SPI_ADDR_LEN = 10;
  localparam int SPI_DATA_LEN = 16;

  localparam int CODE_LSB = 26;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  localparam int CNT_W = $clog2(LEN_SPI + 1);
  localparam int IDX_W = $clog2(LEN_SPI);

  localparam logic [SPI_CODE_LEN-1:0] CMD_DUMMY     = 6'd0;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST   = 6'd7;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_UNRST = 6'd8;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_ELEC   = 6'd10;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ELEC   = 6'd11;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC    = 6'd19;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_CHEM   = 6'd20;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_CHEM   = 6'd21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } state_t;

  function automatic logic [SPI_CODE_LEN-1:0] frame_code(input logic [LEN_SPI-1:0] f);
    return f[CODE_LSB +: SPI_CODE_LEN];
  endfunction

  function automatic logic [SPI_ADDR_LEN-1:0] frame_addr(input logic [LEN_SPI-1:0] f);
    return f[ADDR_LSB +: SPI_ADDR_LEN];
  endfunction

  function automatic logic [SPI_DATA_LEN-1:0] frame_data(input logic [LEN_SPI-1:0] f);
    return f[DATA_LSB +: SPI_DATA_LEN];
  endfunction

endpackage

// File: rtl/spi_cmd_slave_rx_sync_edge.sv
// Multi-flop synchronizer with a history flop producing single-cycle rise/fall pulses.
module spi_cmd_slave_rx_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_cmd_slave_rx.sv
// SPI slave front end: oversamples sck/cs_n/mosi, deserializes LSB-first command
// frames into {code, addr, data}, and shifts a preloaded response word out on miso.
module spi_cmd_slave_rx
  import spi_cmd_slave_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    cmd_valid,
  output logic [SPI_CODE_LEN-1:0] cmd_code,
  output logic [SPI_ADDR_LEN-1:0] cmd_addr,
  output logic [SPI_DATA_LEN-1:0] cmd_data,
  output logic                    frame_err,
  input  logic [LEN_SPI-1:0]      tx_data,
  input  logic                    tx_load,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LEN_SPI);
  localparam int               PRIME_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_cmd_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk_50M), .rst_n(rst_n), .din(sck),
    .dout(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_cmd_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk_50M), .rst_n(rst_n), .din(cs_n),
    .dout(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_cmd_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_50M), .rst_n(rst_n), .din(mosi),
    .dout(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [LEN_SPI-1:0] rx_shift;
  logic [LEN_SPI-1:0] tx_shift;
  logic [LEN_SPI-1:0] shadow;
  logic [LEN_SPI-1:0] tx_src;
  logic               overrun;
  logic               cs_fall_pend;
  logic               armed;
  logic [PRIME_W-1:0] prime_cnt;

  // A tx_load coinciding with frame start feeds the new word straight in.
  assign tx_src = tx_load ? tx_data : shadow;

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      shadow       <= '0;
      overrun      <= 1'b0;
      cs_fall_pend <= 1'b0;
      armed        <= 1'b0;
      prime_cnt    <= '0;
      miso         <= 1'b0;
      busy         <= 1'b0;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
      cmd_code     <= '0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;

      if (tx_load) shadow <= tx_data;

      // After reset the synchronizers hold idle values; only accept a frame start
      // once the real cs_n pin has been seen high, so a frame cut by reset is dropped.
      if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + PRIME_W'(1);
      else if (cs_sync)            armed     <= 1'b1;

      case (state)
        ST_IDLE: begin
          cs_fall_pend <= 1'b0;
          if (armed && (cs_fall || cs_fall_pend)) begin
            bit_cnt  <= '0;
            overrun  <= 1'b0;
            tx_shift <= tx_src;
            miso     <= tx_src[0];
            busy     <= 1'b1;
            state    <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (sck_fall) begin
            if (bit_cnt == FULL_CNT) begin
              overrun <= 1'b1;
            end else begin
              rx_shift[bit_cnt[IDX_W-1:0]] <= mosi_sync;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          if (sck_rise) begin
            tx_shift <= tx_shift >> 1;
            miso     <= tx_shift[1];
          end
          if (cs_rise) state <= ST_END;
        end

        ST_END: begin
          if (bit_cnt == FULL_CNT && !overrun) begin
            cmd_valid <= 1'b1;
            cmd_code  <= frame_code(rx_shift);
            cmd_addr  <= frame_addr(rx_shift);
            cmd_data  <= frame_data(rx_shift);
          end else begin
            frame_err <= 1'b1;
          end
          if (cs_fall) cs_fall_pend <= 1'b1;
          busy  <= 1'b0;
          miso  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave_rx.sv
// Directed bench for spi_cmd_slave_rx: SPI master driver, expected-command queue,
// strobe monitor and miso capture checks.
module tb_spi_cmd_slave_rx;

  logic        clk_50M;
  logic        rst_n;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_code;
  logic [9:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        busy;

  spi_cmd_slave_rx dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .busy      (busy)
  );

  // Clock / reset
  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_errors = 0;

  // {is_err, code[5:0], addr[9:0], data[15:0]}
  logic [32:0] exp_q[$];
  logic [31:0] last_good;
  logic [31:0] miso_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic [5:0] code, input logic [9:0] addr, input logic [15:0] data);
    last_good = {code, addr, data};
    exp_q.push_back({1'b0, code, addr, data});
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, last_good});
  endtask

  // Driver: bits [from, to) of a frame; the master samples miso on each sck fall.
  task automatic spi_bits(input logic [31:0] word, input int from, input int to);
    for (int i = from; i < to; i++) begin
      mosi = (i < 32) ? word[i] : 1'b0;
      #100;
      sck = 1'b0;
      if (i < 32) miso_word[i] = miso;
      #100;
      sck = 1'b1;
    end
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits);
    miso_word = '0;
    cs_n = 1'b0;
    #200;
    spi_bits(word, 0, nbits);
    #100;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic load_tx(input logic [31:0] w);
    @(negedge clk_50M);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk_50M);
    tx_load = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk_50M) begin
    if (rst_n && (cmd_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected none", cmd_valid, frame_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("strobe_kind", {30'd0, cmd_valid, frame_err}, e[32] ? 32'd1 : 32'd2);
        check("cmd_code", {26'd0, cmd_code}, {26'd0, e[31:26]});
        check("cmd_addr", {22'd0, cmd_addr}, {22'd0, e[25:16]});
        check("cmd_data", {16'd0, cmd_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sck = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0;
    last_good = '0; miso_word = '0;
    repeat (5) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    check("rst_outputs", {28'd0, miso, cmd_valid, frame_err, busy}, 32'd0);
    check("rst_cmd", {cmd_code, cmd_addr, cmd_data}, 32'd0);
    repeat (10) @(negedge clk_50M);

    // code 8, addr 4, data 0; shadow still zero so miso returns zeros
    expect_cmd(6'd8, 10'd4, 16'h0000);
    spi_frame(32'h2004_0000, 32);
    check("miso_shadow_zero", miso_word, 32'h0000_0000);

    // code 4, addr 9, data 0x001D, then a dummy frame
    expect_cmd(6'd4, 10'd9, 16'h001D);
    spi_frame(32'h1009_001D, 32);
    expect_cmd(6'd0, 10'd0, 16'h0000);
    spi_frame(32'h0000_0000, 32);

    // response word, sent twice without reload; busy high mid-frame
    load_tx(32'hA5A5_3C3C);
    expect_cmd(6'd10, 10'h155, 16'hBEEF);
    miso_word = '0;
    cs_n = 1'b0;
    #200;
    spi_bits(32'h2955_BEEF, 0, 5);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    spi_bits(32'h2955_BEEF, 5, 32);
    #100; cs_n = 1'b1; #200;
    check("miso_word_1", miso_word, 32'hA5A5_3C3C);
    expect_cmd(6'd11, 10'd3, 16'h1234);
    spi_frame(32'h2C03_1234, 32);
    check("miso_word_2", miso_word, 32'hA5A5_3C3C);

    // truncated and overlong frames
    expect_err();
    spi_frame(32'h2C03_1234, 20);
    expect_err();
    spi_frame(32'h4C00_1111, 33);

    // reset mid-frame at bit 10: no strobe, fields cleared
    miso_word = '0;
    cs_n = 1'b0;
    #200;
    spi_bits(32'h1234_5678, 0, 10);
    @(negedge clk_50M);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    check("abort_rst_cmd", {cmd_code, cmd_addr, cmd_data}, 32'd0);
    check("abort_rst_busy", {31'd0, busy}, 32'd0);
    last_good = '0;
    spi_bits(32'h1234_5678, 10, 32);
    #100; cs_n = 1'b1; #200;
    expect_cmd(6'd20, 10'h02A, 16'h5A5A);
    spi_frame(32'h502A_5A5A, 32);
    check("miso_after_reset", miso_word, 32'h0000_0000);

    // ten back-to-back code 19 reads
    for (int i = 0; i < 10; i++) begin
      logic [15:0] d;
      d = 16'h0101 * 16'(i);
      expect_cmd(6'd19, 10'(i), d);
      spi_frame(32'h4C00_0000 | (32'(i) << 16) | {16'd0, d}, 32);
    end

    repeat (50) @(negedge clk_50M);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
